// File: rtl/dac_feed_if.sv
// Valid/ready sample channel between a producer and the DAC sample feeder.
interface dac_feed_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/dac_sample_feeder.sv
// Sample FIFO feeding the PWM DAC one code per frame; dac_out changes only at frame boundaries.
// Optional DAC_FEED_UNDERRUN_CNT_EN adds a saturating underrun_count output.
module dac_sample_feeder #(
  parameter int                DATA_W        = 12,
  parameter int                DEPTH         = 8,
  parameter int                FRAME_BITS    = 12,
  parameter logic [DATA_W-1:0] IDLE_CODE     = 12'h800,
  parameter bit                UNDERRUN_MODE = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  dac_feed_if.slave                s_if,
  output logic [DATA_W-1:0]        dac_out,
  output logic                     frame_start,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     underrun
`ifdef DAC_FEED_UNDERRUN_CNT_EN
  ,
  output logic [15:0]              underrun_count
`endif
);
  localparam int AW = $clog2(DEPTH);

  logic [FRAME_BITS-1:0] fc_q, fc_d;
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DATA_W-1:0]     mem_d [DEPTH];
  logic [DATA_W-1:0]     dac_q, dac_d;
  logic                  frame_start_q, frame_start_d;
  logic                  underrun_q, underrun_d;
  logic [AW:0]           count;
  logic                  empty, full, boundary, push, pop;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Occupancy from the wrap-bit pointers; difference is exact up to DEPTH
  assign count    = wr_ptr_q - rd_ptr_q;
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign boundary = (fc_q == '1);
  assign push     = s_if.s_valid && !full;
  assign pop      = boundary && !empty;

  always_comb begin
    fc_d          = fc_q + FRAME_BITS'(1);
    wr_ptr_d      = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d      = rd_ptr_q + (AW+1)'(pop);
    mem_d         = mem_q;
    dac_d         = dac_q;
    frame_start_d = boundary;
    underrun_d    = boundary && empty;
    if (push) mem_d[wr_ptr_q[AW-1:0]] = s_if.s_data;
    // An empty FIFO at the boundary is an underrun even if a push lands on the same edge
    if (boundary) begin
      if (!empty)             dac_d = mem_q[rd_ptr_q[AW-1:0]];
      else if (UNDERRUN_MODE) dac_d = IDLE_CODE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc_q          <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      dac_q         <= IDLE_CODE;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      fc_q          <= fc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      dac_q         <= dac_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  // Sample storage carries no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef DAC_FEED_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_q, underrun_cnt_d;

  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    if (underrun_d) underrun_cnt_d = sat_inc16(underrun_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) underrun_cnt_q <= '0;
    else        underrun_cnt_q <= underrun_cnt_d;
  end

  assign underrun_count = underrun_cnt_q;
`endif

  assign s_if.s_ready = !full;
  assign dac_out      = dac_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;
  assign fill_level   = count;
endmodule

// File: tb/tb_dac_sample_feeder.sv
// Directed bench for dac_sample_feeder: 16-clock frames, DEPTH=4, hold (dut0) and idle (dut1) underrun modes.
module tb_dac_sample_feeder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dac_feed_if #(.DATA_W(12)) if0 ();
  dac_feed_if #(.DATA_W(12)) if1 ();

  logic [11:0] dac0, dac1;
  logic        fs0, fs1, ur0, ur1;
  logic [2:0]  fill0, fill1;
`ifdef DAC_FEED_UNDERRUN_CNT_EN
  logic [15:0] cnt0, cnt1;
`endif

  dac_sample_feeder #(.DATA_W(12), .DEPTH(4), .FRAME_BITS(4), .IDLE_CODE(12'h800),
                      .UNDERRUN_MODE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .s_if(if0.slave), .dac_out(dac0), .frame_start(fs0),
    .fill_level(fill0), .underrun(ur0)
`ifdef DAC_FEED_UNDERRUN_CNT_EN
    , .underrun_count(cnt0)
`endif
  );

  dac_sample_feeder #(.DATA_W(12), .DEPTH(4), .FRAME_BITS(4), .IDLE_CODE(12'h800),
                      .UNDERRUN_MODE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_if(if1.slave), .dac_out(dac1), .frame_start(fs1),
    .fill_level(fill1), .underrun(ur1)
`ifdef DAC_FEED_UNDERRUN_CNT_EN
    , .underrun_count(cnt1)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic drive(input logic v, input logic [11:0] d);
    if0.s_valid = v; if0.s_data = d;
    if1.s_valid = v; if1.s_data = d;
  endtask

  task automatic reset_dut();
    drive(1'b0, 12'h000);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_dac", 32'(dac0), 32'h800);
    chk("rst_fill", 32'(fill0), 32'd0);
    chk("rst_ready", 32'(if0.s_ready), 32'd1);
    chk("rst_fs_ur", {fs0, ur0}, 32'd0);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  // Holds the word until the edge that accepts it; returns the accepting cycle
  task automatic push(input logic [11:0] d, output int acc_cyc);
    logic rdy;
    int   n;
    drive(1'b1, d);
    acc_cyc = -1;
    n = 0;
    while (acc_cyc < 0 && n < 100) begin
      rdy = if0.s_ready;
      step();
      if (rdy) acc_cyc = cyc - 1;
      n++;
    end
    if (acc_cyc < 0) chk("push_timeout", 32'd0, 32'd1);
    drive(1'b0, 12'h000);
  endtask

  initial begin
    drive(1'b0, 12'h000);

    // 1: idle run, underrun pulses on every boundary after the reset frame
    reset_dut();
    for (int i = 0; i < 40; i++) begin
      step();
      chk("t1_ur", 32'(ur0), 32'((cyc % 16 == 0) ? 1 : 0));
      chk("t1_fs", 32'(fs0), 32'((cyc % 16 == 0) ? 1 : 0));
      chk("t1_dac", 32'(dac0), 32'h800);
      chk("t1_dac_m1", 32'(dac1), 32'h800);
      chk("t1_ready", 32'(if0.s_ready), 32'd1);
    end

    // 2: single sample, shown on the first boundary
    reset_dut();
    step_to(3);
    push(12'h123, acc);
    chk("t2_fill", 32'(fill0), 32'd1);
    step_to(15);
    chk("t2_dac15", 32'(dac0), 32'h800);
    chk("t2_fs15", 32'(fs0), 32'd0);
    step_to(16);
    chk("t2_dac16", 32'(dac0), 32'h123);
    chk("t2_fs16", 32'(fs0), 32'd1);
    chk("t2_ur16", 32'(ur0), 32'd0);
    chk("t2_fill16", 32'(fill0), 32'd0);
    step_to(31);
    chk("t2_dac31", 32'(dac0), 32'h123);
    step_to(32);
    chk("t2_ur32", 32'(ur0), 32'd1);
    chk("t2_hold32", 32'(dac0), 32'h123);
    chk("t2_idle32_m1", 32'(dac1), 32'h800);

    // 3: burst of five into a four-deep FIFO
    reset_dut();
    step_to(1);
    for (int i = 1; i <= 4; i++) begin
      push(12'(i), acc);
      chk("t3_acc", 32'(acc), 32'(i));
    end
    chk("t3_full_ready", 32'(if0.s_ready), 32'd0);
    chk("t3_full_fill", 32'(fill0), 32'd4);
    step_to(15);
    chk("t3_ready15", 32'(if0.s_ready), 32'd0);
    push(12'h005, acc);
    chk("t3_acc5", 32'(acc), 32'd16);
    chk("t3_dac17", 32'(dac0), 32'h001);
    chk("t3_fill17", 32'(fill0), 32'd4);
    for (int k = 2; k <= 5; k++) begin
      step_to(16 * k - 1);
      chk("t3_dac_before", 32'(dac0), 32'(k - 1));
      step_to(16 * k);
      chk("t3_dac_step", 32'(dac0), 32'(k));
      chk("t3_ur_step", 32'(ur0), 32'd0);
    end
    step_to(96);
    chk("t3_ur96", 32'(ur0), 32'd1);
    chk("t3_fill96", 32'(fill0), 32'd0);
    chk("t3_hold96", 32'(dac0), 32'h005);
    chk("t3_idle96_m1", 32'(dac1), 32'h800);

    // 4: push landing on the boundary edge of an empty FIFO
    reset_dut();
    step_to(2);
    push(12'h111, acc);
    step_to(16);
    chk("t4_dac16", 32'(dac0), 32'h111);
    chk("t4_dac16_m1", 32'(dac1), 32'h111);
    step_to(31);
    drive(1'b1, 12'hABC);
    chk("t4_ready31", 32'(if0.s_ready), 32'd1);
    step();
    drive(1'b0, 12'h000);
    chk("t4_ur32", 32'(ur0), 32'd1);
    chk("t4_ur32_m1", 32'(ur1), 32'd1);
    chk("t4_hold32", 32'(dac0), 32'h111);
    chk("t4_idle32_m1", 32'(dac1), 32'h800);
    chk("t4_fill32", 32'(fill0), 32'd1);
    step_to(47);
    chk("t4_hold47", 32'(dac0), 32'h111);
    chk("t4_idle47_m1", 32'(dac1), 32'h800);
    step_to(48);
    chk("t4_dac48", 32'(dac0), 32'hABC);
    chk("t4_dac48_m1", 32'(dac1), 32'hABC);
    chk("t4_ur48", 32'(ur0), 32'd0);
    chk("t4_fill48", 32'(fill0), 32'd0);

    // 5: asynchronous reset mid-frame with three entries queued
    reset_dut();
    step_to(2);
    push(12'h5A5, acc);
    step_to(17);
    push(12'h0A1, acc);
    push(12'h0A2, acc);
    push(12'h0A3, acc);
    step_to(24);
    chk("t5_fill24", 32'(fill0), 32'd3);
    chk("t5_dac24", 32'(dac0), 32'h5A5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_dac", 32'(dac0), 32'h800);
    chk("t5_async_fill", 32'(fill0), 32'd0);
    chk("t5_async_ready", 32'(if0.s_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    step_to(15);
    chk("t5_fs15", 32'(fs0), 32'd0);
    step_to(16);
    chk("t5_fs16", 32'(fs0), 32'd1);
    chk("t5_ur16", 32'(ur0), 32'd1);
    chk("t5_dac16", 32'(dac0), 32'h800);
    chk("t5_fill16", 32'(fill0), 32'd0);

`ifdef DAC_FEED_UNDERRUN_CNT_EN
    // 6: underrun counter and its saturation
    reset_dut();
    chk("t6_cnt0", 32'(cnt0), 32'd0);
    step_to(80);
    chk("t6_cnt80", 32'(cnt0), 32'd5);
    step_to(81);
    force dut0.underrun_cnt_q = 16'hFFFE;
    #1;
    release dut0.underrun_cnt_q;
    step_to(95);
    chk("t6_cnt95", 32'(cnt0), 32'hFFFE);
    step_to(96);
    chk("t6_cnt96", 32'(cnt0), 32'hFFFF);
    step_to(112);
    chk("t6_cnt112", 32'(cnt0), 32'hFFFF);
    step_to(128);
    chk("t6_cnt128", 32'(cnt0), 32'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
